// File: rtl/speccfa_meta_loader_if.sv
// Receive-stream and peripheral-bus signals of the SpecCFA metadata loader.
// The master modport is the loader side; the slave modport is the stream source / bus target side.
interface speccfa_meta_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, per_addr, per_din, per_en, per_we
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, per_addr, per_din, per_en, per_we
    );
endinterface

// File: rtl/speccfa_meta_loader.sv
// Fills SpecCFA block-metadata memory from framed byte packets:
// SYNC, COUNT, 2*COUNT little-endian data bytes, XOR checksum.
module speccfa_meta_loader #(
    parameter logic [14:0] BASE_ADDR = 15'h0400,
    parameter int unsigned MEM_WORDS = 256,
    parameter logic [7:0]  SYNC      = 8'hA5
) (
    input  logic                          mclk,
    input  logic                          puc_rst,
    speccfa_meta_loader_if.master         bus,
    output logic                          busy,
    output logic                          meta_valid,
    output logic                          load_err,
    output logic [7:0]                    words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_LO,
        S_HI,
        S_WRITE,
        S_CHK
    } state_t;

    state_t      state, state_next;
    logic [7:0]  n_words;
    logic [7:0]  index;
    logic [7:0]  csum;
    logic [7:0]  lo_byte;
    logic [13:0] per_addr_q;
    logic [15:0] per_din_q;
    logic        per_en_q;
    logic [1:0]  per_we_q;
    logic        rx_ready_c;
    logic        accept;
    logic        too_big;
    logic        last_word;

    assign rx_ready_c = (state != S_WRITE);
    assign accept     = bus.rx_valid && rx_ready_c;
    assign too_big    = 32'(bus.rx_data) > MEM_WORDS;
    assign last_word  = (index + 8'd1) == n_words;

    assign bus.rx_ready = rx_ready_c;
    assign bus.per_addr = per_addr_q;
    assign bus.per_din  = per_din_q;
    assign bus.per_en   = per_en_q;
    assign bus.per_we   = per_we_q;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept && bus.rx_data == SYNC) state_next = S_COUNT;
            S_COUNT: if (accept) begin
                         if (bus.rx_data == 8'd0) state_next = S_CHK;
                         else if (too_big)        state_next = S_IDLE;
                         else                     state_next = S_LO;
                     end
            S_LO:    if (accept) state_next = S_HI;
            S_HI:    if (accept) state_next = S_WRITE;
            S_WRITE: state_next = last_word ? S_CHK : S_LO;
            S_CHK:   if (accept) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            state        <= S_IDLE;
            n_words      <= '0;
            index        <= '0;
            csum         <= '0;
            lo_byte      <= '0;
            per_addr_q   <= '0;
            per_din_q    <= '0;
            per_en_q     <= 1'b0;
            per_we_q     <= '0;
            busy         <= 1'b0;
            meta_valid   <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
        end else begin
            state    <= state_next;
            per_en_q <= 1'b0;
            per_we_q <= '0;
            case (state)
                S_IDLE: if (accept && bus.rx_data == SYNC) begin
                    busy         <= 1'b1;
                    meta_valid   <= 1'b0;
                    load_err     <= 1'b0;
                    words_loaded <= '0;
                    index        <= '0;
                    csum         <= '0;
                end
                S_COUNT: if (accept) begin
                    n_words <= bus.rx_data;
                    csum    <= csum ^ bus.rx_data;
                    if (bus.rx_data != 8'd0 && too_big) begin
                        load_err <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                S_LO: if (accept) begin
                    lo_byte <= bus.rx_data;
                    csum    <= csum ^ bus.rx_data;
                end
                // Bus cycle is launched on the HI byte so per_en is registered and lines up with WRITE.
                S_HI: if (accept) begin
                    csum       <= csum ^ bus.rx_data;
                    per_en_q   <= 1'b1;
                    per_we_q   <= 2'b11;
                    per_addr_q <= BASE_ADDR[14:1] + {6'd0, index};
                    per_din_q  <= {bus.rx_data, lo_byte};
                end
                S_WRITE: begin
                    index        <= index + 8'd1;
                    words_loaded <= words_loaded + 8'd1;
                end
                S_CHK: if (accept) begin
                    if (bus.rx_data == csum) meta_valid <= 1'b1;
                    else                     load_err   <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
